// File: rtl/seq_onehot_decoder.sv
// Registered SEL_W-to-2**SEL_W one-hot select decoder with valid/ready intake.
// Level mode holds the word until the next command; pulse mode holds it PULSE_LEN cycles.
module seq_onehot_decoder #(
    parameter int SEL_W     = 4,
    parameter int PULSE_LEN = 1
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    en_n_in,
    input  logic                    mode_in,
    input  logic                    in_valid_in,
    output logic                    in_ready_out,
    input  logic [SEL_W-1:0]        sel_in,
    output logic [(1<<SEL_W)-1:0]   y_out,
    output logic                    out_valid_out,
    output logic                    ovf_out
);
    localparam int OUT_W = 1 << SEL_W;
    localparam int CNT_W = ($clog2(PULSE_LEN + 1) < 1) ? 1 : $clog2(PULSE_LEN + 1);

    typedef enum logic [1:0] {IDLE, HOLD, PULSE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [OUT_W-1:0]   y, y_nxt;
    logic               mode_q, mode_nxt;
    logic               ovf, ovf_nxt;
    logic               live;
    logic               accept;

    assign in_ready_out = !en_n_in && (state == IDLE || state == HOLD);
    assign accept       = in_valid_in && in_ready_out;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state  <= IDLE;
            cnt    <= '0;
            y      <= '0;
            mode_q <= 1'b0;
            ovf    <= 1'b0;
            live   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            y      <= y_nxt;
            mode_q <= mode_nxt;
            ovf    <= ovf_nxt;
            live   <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        y_nxt     = y;
        mode_nxt  = mode_q;
        ovf_nxt   = ovf;
        if (en_n_in) begin
            // Disable wins over everything, including a running pulse.
            state_nxt = IDLE;
            cnt_nxt   = '0;
            y_nxt     = '0;
            ovf_nxt   = 1'b0;
        end else begin
            if (in_valid_in && !in_ready_out)
                ovf_nxt = 1'b1;
            if (accept) begin
                y_nxt    = {{(OUT_W-1){1'b0}}, 1'b1} << sel_in;
                mode_nxt = mode_in;
                if (mode_in) begin
                    state_nxt = PULSE;
                    cnt_nxt   = CNT_W'(PULSE_LEN - 1);
                end else begin
                    state_nxt = HOLD;
                end
            end else if (state == PULSE && mode_q) begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    y_nxt     = '0;
                    state_nxt = IDLE;
                end
            end
        end
    end

    assign y_out         = y;
    assign out_valid_out = live;
    assign ovf_out       = ovf;
endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Randomised and directed bench for seq_onehot_decoder against a cycle-level reference model.
module tb_seq_onehot_decoder;
    localparam int PL = 3;

    logic clk = 0, rst_n = 0;
    logic en_n = 0, mode = 0, valid = 0;
    logic [3:0] sel = 0;
    logic rdy, ov, ovf;
    logic [15:0] y;

    logic en2_n = 1, mode2 = 0, valid2 = 0;
    logic [2:0] sel2 = 0;
    logic rdy2, ov2, ovf2;
    logic [7:0] y2;

    int total = 0, bad = 0;

    // reference model state
    logic [15:0] m_word;
    int          m_left;
    logic        m_ovf;

    always #5 clk = ~clk;

    seq_onehot_decoder #(.SEL_W(4), .PULSE_LEN(PL)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .en_n_in(en_n), .mode_in(mode),
        .in_valid_in(valid), .in_ready_out(rdy), .sel_in(sel),
        .y_out(y), .out_valid_out(ov), .ovf_out(ovf));

    seq_onehot_decoder #(.SEL_W(3), .PULSE_LEN(1)) dut3 (
        .clk_in(clk), .rst_n_in(rst_n), .en_n_in(en2_n), .mode_in(mode2),
        .in_valid_in(valid2), .in_ready_out(rdy2), .sel_in(sel2),
        .y_out(y2), .out_valid_out(ov2), .ovf_out(ovf2));

    function automatic logic m_ready();
        return !en_n && (m_left == 0);
    endfunction

    task automatic model_reset();
        m_word = '0; m_left = 0; m_ovf = 0;
    endtask

    // One clock: model consumes the inputs present at the rising edge; returns at the falling edge.
    task automatic tick();
        logic r;
        @(posedge clk);
        r = m_ready();
        if (en_n) begin
            model_reset();
        end else begin
            if (valid && !r) m_ovf = 1;
            if (valid && r) begin
                m_word = '0; m_word[sel] = 1'b1;
                m_left = mode ? PL : 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_word = '0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; en_n = 0; valid = 0; model_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({y, ov, ovf} !== 18'h0) begin
            bad++; $display("FAIL reset: got y=%h v=%b o=%b want 0", y, ov, ovf);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_w [2] = '{16'h0001, 16'h1000};
        logic [3:0]  codes [2] = '{4'h0, 4'hC};
        for (int i = 0; i < 2; i++) begin
            en_n = 0; mode = 0; valid = 1; sel = codes[i];
            tick();
            total++;
            if (y !== exp_w[i] || ov !== 1'b1 || ovf !== 1'b0) begin
                bad++; $display("FAIL b2b[%0d]: got y=%h v=%b o=%b want y=%h v=1 o=0", i, y, ov, ovf, exp_w[i]);
            end
        end
        valid = 0;
    endtask

    task automatic test_sweep();
        for (int s = 0; s < 16; s++) begin
            mode = 0; valid = 1; sel = 4'(s);
            tick();
            total++;
            if (y !== m_word || $countones(y) != 1 || ov !== 1'b1) begin
                bad++; $display("FAIL sweep sel=%0d: got y=%h v=%b want y=%h", s, y, ov, m_word);
            end
        end
        valid = 0;
    endtask

    task automatic test_pulse();
        int seen = 0;
        mode = 1; valid = 1; sel = 4'd5;
        tick();
        valid = 0;
        for (int c = 0; c < 6; c++) begin
            total++;
            if (y !== m_word || ov !== (m_word != 0) || rdy !== m_ready()) begin
                bad++; $display("FAIL pulse c%0d: got y=%h v=%b r=%b want y=%h r=%b", c, y, ov, rdy, m_word, m_ready());
            end
            if (y === 16'h0020) seen++;
            tick();
        end
        total++;
        if (seen != PL) begin
            bad++; $display("FAIL pulse_len: got %0d cycles want %0d", seen, PL);
        end
    endtask

    task automatic test_overrun();
        int seen7 = 0;
        mode = 1; valid = 1; sel = 4'd5;
        tick();
        sel = 4'd7;
        for (int c = 0; c < 8; c++) begin
            total++;
            if (y !== m_word || ovf !== m_ovf || ov !== (m_word != 0) || rdy !== m_ready()) begin
                bad++; $display("FAIL overrun c%0d: got y=%h o=%b r=%b want y=%h o=%b r=%b", c, y, ovf, rdy, m_word, m_ovf, m_ready());
            end
            if (y === 16'h0080) seen7++;
            if (c == 4) valid = 0;
            tick();
        end
        total++;
        if (seen7 != PL || ovf !== 1'b1) begin
            bad++; $display("FAIL overrun_sum: got y80 cycles=%0d ovf=%b want %0d,1", seen7, ovf, PL);
        end
    endtask

    task automatic test_disable();
        mode = 0; valid = 1; sel = 4'd9;
        tick();
        valid = 0;
        total++;
        if (y !== 16'h0200) begin
            bad++; $display("FAIL dis_pre: got y=%h want 0200", y);
        end
        en_n = 1; valid = 1;
        #1;
        total++;
        if (rdy !== 1'b0) begin
            bad++; $display("FAIL dis_ready: got %b want 0", rdy);
        end
        tick();
        total++;
        if (y !== 16'h0 || ov !== 1'b0 || ovf !== 1'b0 || rdy !== 1'b0) begin
            bad++; $display("FAIL disable: got y=%h v=%b o=%b r=%b want 0", y, ov, ovf, rdy);
        end
        en_n = 0; valid = 0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            en_n  = ($urandom_range(0, 15) == 0);
            valid = $urandom_range(0, 1);
            mode  = $urandom_range(0, 1);
            sel   = 4'($urandom);
            #1;
            total++;
            if (rdy !== m_ready()) begin
                bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, rdy, m_ready());
            end
            tick();
            total++;
            if (y !== m_word || ov !== (m_word != 0) || ovf !== m_ovf) begin
                bad++; $display("FAIL rnd c%0d: got y=%h v=%b o=%b want y=%h v=%b o=%b", c, y, ov, ovf, m_word, m_word != 0, m_ovf);
            end
        end
        en_n = 0; valid = 0;
        repeat (PL + 1) tick();
    endtask

    task automatic test_async_reset();
        mode = 1; valid = 1; sel = 4'd3;
        tick();
        tick();
        total++;
        if (y !== 16'h0008 || ovf !== 1'b1) begin
            bad++; $display("FAIL ar_pre: got y=%h o=%b want 0008,1", y, ovf);
        end
        valid = 0;
        #2 rst_n = 0;
        #1;
        total++;
        if ({y, ov, ovf} !== 18'h0) begin
            bad++; $display("FAIL async_reset: got y=%h v=%b o=%b want 0", y, ov, ovf);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        mode = 0; valid = 1; sel = 4'd1;
        tick();
        valid = 0;
        total++;
        if (y !== 16'h0002 || ov !== 1'b1) begin
            bad++; $display("FAIL ar_post: got y=%h v=%b want 0002,1", y, ov);
        end
    endtask

    task automatic test_sel3();
        en2_n = 0;
        for (int s = 0; s < 8; s++) begin
            mode2 = 0; valid2 = 1; sel2 = 3'(s);
            @(posedge clk); @(negedge clk);
            total++;
            if (y2 !== 8'(1 << s)) begin
                bad++; $display("FAIL sel3 s=%0d: got %h want %h", s, y2, 8'(1 << s));
            end
        end
        total++;
        if (y2 !== 8'h80) begin
            bad++; $display("FAIL sel3_top: got %h want 80", y2);
        end
        mode2 = 1; sel2 = 3'd2;
        @(posedge clk); @(negedge clk);
        valid2 = 0;
        total++;
        if (y2 !== 8'h04 || rdy2 !== 1'b0) begin
            bad++; $display("FAIL sel3_pulse: got y=%h r=%b want 04,0", y2, rdy2);
        end
        @(posedge clk); @(negedge clk);
        total++;
        if (y2 !== 8'h00 || ov2 !== 1'b0 || rdy2 !== 1'b1 || ovf2 !== 1'b0) begin
            bad++; $display("FAIL sel3_end: got y=%h v=%b r=%b o=%b want 00,0,1,0", y2, ov2, rdy2, ovf2);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_sweep();
        test_pulse();
        test_overrun();
        test_disable();
        test_random();
        test_async_reset();
        test_sel3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
